wb_retire_stage: RTL and testbench
==================================

// Module: wb_retire_stage
// PURPOSE
//   Parametrised write-back stage. Buffers instructions from the MEM stage in a DEPTH-entry retire FIFO.
//   Arbitrates the single regfile write port between the FIFO head and a long-latency unit (mul/div) result.
//   Exports a pending-destination mask so decode can stall on buffered writes, and drives the debug trace.
// PARAMETERS
//   DATA_W  32  regfile data width
//   ADDR_W  5   regfile address width; mask width is 2**ADDR_W
//   PC_W    32  PC width carried for trace
//   DEPTH   4   retire FIFO entries; power of two, >=2
// PORTS
//   clk              in   1             clock
//   reset            in   1             synchronous, active-high reset
//   ms_to_ws_valid   in   1             MEM stage presents an instruction
//   ms_gr_we         in   1             instruction writes the regfile
//   ms_dest          in   ADDR_W        destination register
//   ms_result        in   DATA_W        result data
//   ms_pc            in   PC_W          instruction PC
//   ws_allowin       out  1             stage can accept from MEM this cycle
//   lu_valid         in   1             long-latency unit result valid; always consumed (lu_ready=1)
//   lu_dest          in   ADDR_W        long-unit destination
//   lu_data          in   DATA_W        long-unit result
//   lu_pc            in   PC_W          long-unit instruction PC
//   rf_we            out  1             regfile write enable
//   rf_waddr         out  ADDR_W        regfile write address
//   rf_wdata         out  DATA_W        regfile write data
//   pend_mask        out  2**ADDR_W     bit d set: a valid FIFO entry will write register d
//   fwd_valid        out  1             forwarding record valid (WB_FWD_EN only)
//   fwd_dest         out  ADDR_W        forwarding destination
//   fwd_data         out  DATA_W        forwarding data
//   debug_wb_pc      out  PC_W          retired PC
//   debug_wb_rf_wen  out  4             {4{rf_we}}
//   debug_wb_rf_wnum out  ADDR_W        = rf_waddr
//   debug_wb_rf_wdata out DATA_W        = rf_wdata
// BEHAVIOUR
//   - Reset: FIFO empty; wr_ptr, rd_ptr and count = 0; all outputs 0; ws_allowin = 1.
//   - Push: ms_to_ws_valid && ws_allowin writes {gr_we,dest,result,pc} at wr_ptr on the clock edge.
//   - ws_allowin = (count != DEPTH) || pop; a full FIFO accepts when the head retires the same cycle.
//   - Retire port priority: lu_valid wins. If lu_valid, drive rf = {1,lu_dest,lu_data}; trace pc = lu_pc; no pop.
//   - Otherwise, if count != 0, pop the head. rf_we = head.gr_we; addr, data and pc come from the head.
//   - Entries with gr_we=0 still pop and set debug_wb_pc, with rf_we=0.
//   - Idle (no lu, FIFO empty): rf_we=0; debug outputs hold 0.
//   - rf_we is forced to 0 whenever the write address is 0. This applies to both sources.
//   - Latency: an instruction pushed at edge t is earliest at rf in cycle t+1 (head drives rf combinationally).
//   - Simultaneous push and pop: count unchanged. A push into an empty FIFO is not visible to pop in the same cycle.
//   - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
//   - pend_mask is the OR over valid entries with gr_we=1 and dest!=0. It includes the head being popped this cycle.
//   - Entry validity comes from count/pointers only; stale data in freed slots never affects the mask.
//   - Reset mid-operation: all buffered entries are discarded, with no write on the reset cycle.
//   - Continuous lu_valid starves the FIFO by design; the decode/issue logic bounds the lu issue rate.
// CONFIGURATION
//   WB_FWD_EN defined:
//     fwd_* carries the newest matching producer.
//     If lu_valid: {1,lu_dest,lu_data}. Else the youngest FIFO entry (wr_ptr-1) if count!=0 and its gr_we=1.
//     Else fwd_valid=0.
//   WB_FWD_EN undefined: fwd_valid, fwd_dest and fwd_data tied to 0; decode relies on pend_mask stalls only.
// TESTING
//   1 Reset, then push {we=1,dest=5,data=32'h1234,pc=32'hbfc00000}:
//     next cycle rf_we=1, waddr=5, wdata=32'h1234; debug_wb_rf_wen=4'hf.
//   2 Push 6 back-to-back with lu_valid=1 held for 5 cycles (DEPTH=4):
//     ws_allowin drops after 4 pushes; no rf write from the FIFO; all lu writes land.
//     The FIFO then drains in order.
//   3 Full FIFO; lu_valid=0; push in the same cycle:
//     ws_allowin=1, count stays 4, head retires, the new entry is at the tail.
//   4 Entries dest=3 (we=1), dest=7 (we=0), dest=0 (we=1):
//     pend_mask = 32'h8 only; the dest=0 retire gives rf_we=0.
//   5 Reset asserted with 3 buffered entries:
//     the next cycle has count=0, rf_we=0, pend_mask=0 and no stale writes afterwards.
//   6 With WB_FWD_EN: push dest=9 data=32'hA then dest=9 data=32'hB while the head is stalled by lu:
//     fwd = {1,9,32'hB}. Without the macro, fwd_valid=0 throughout.

Source files
------------

// File: rtl/wb_retire_stage.sv
// Write-back / retire stage.
// MEM-stage instructions are buffered in a DEPTH-entry retire FIFO. The FIFO head and the
// long-latency unit (mul/div) share the single regfile write port, and the long unit has priority.
// The stage also exports a pending-destination mask for decode stalls and drives the debug trace.
// Optional feature macro: WB_FWD_EN. When it is defined, fwd_* carries the newest producer.
// When it is undefined, fwd_* is tied to zero.
module wb_retire_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ms_to_ws_valid,
    input  logic                     ms_gr_we,
    input  logic [ADDR_W-1:0]        ms_dest,
    input  logic [DATA_W-1:0]        ms_result,
    input  logic [PC_W-1:0]          ms_pc,
    output logic                     ws_allowin,
    input  logic                     lu_valid,
    input  logic [ADDR_W-1:0]        lu_dest,
    input  logic [DATA_W-1:0]        lu_data,
    input  logic [PC_W-1:0]          lu_pc,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [(2**ADDR_W)-1:0]   pend_mask,
    output logic                     fwd_valid,
    output logic [ADDR_W-1:0]        fwd_dest,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [PC_W-1:0]          debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [ADDR_W-1:0]        debug_wb_rf_wnum,
    output logic [DATA_W-1:0]        debug_wb_rf_wdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // FIFO storage. Validity is derived only from the pointers and the count.
    logic              fifo_we   [DEPTH];
    logic [ADDR_W-1:0] fifo_dest [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PC_W-1:0]   fifo_pc   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [PC_W-1:0]   sel_pc;

    logic [PTR_W-1:0] mask_idx;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));
    // The long unit owns the port whenever it is valid, so the head only retires when lu is idle.
    assign pop        = !reset && !lu_valid && !fifo_empty;
    assign ws_allowin = !fifo_full || pop;
    assign push       = ms_to_ws_valid && ws_allowin;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Entry payload write. Slots are not cleared because stale contents are never treated as valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_we[wr_ptr]   <= ms_gr_we;
            fifo_dest[wr_ptr] <= ms_dest;
            fifo_data[wr_ptr] <= ms_result;
            fifo_pc[wr_ptr]   <= ms_pc;
        end
    end

    // Retire-port arbitration. The long unit wins; otherwise the FIFO head drives the port.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_pc   = '0;
        if (reset) begin
            sel_we = 1'b0;
        end else if (lu_valid) begin
            sel_we   = 1'b1;
            sel_addr = lu_dest;
            sel_data = lu_data;
            sel_pc   = lu_pc;
        end else if (!fifo_empty) begin
            sel_we   = fifo_we[rd_ptr];
            sel_addr = fifo_dest[rd_ptr];
            sel_data = fifo_data[rd_ptr];
            sel_pc   = fifo_pc[rd_ptr];
        end
    end

    // r0 is never written, whichever source owns the port.
    assign rf_we             = sel_we && (sel_addr != '0);
    assign rf_waddr          = sel_addr;
    assign rf_wdata          = sel_data;
    assign debug_wb_pc       = sel_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = sel_addr;
    assign debug_wb_rf_wdata = sel_data;

    // Pending-destination mask over the live entries, including the head that retires this cycle.
    always_comb begin
        pend_mask = '0;
        mask_idx  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (CNT_W'(k) < count) begin
                mask_idx = rd_ptr + PTR_W'(k);
                if (fifo_we[mask_idx] && (fifo_dest[mask_idx] != '0)) begin
                    pend_mask[fifo_dest[mask_idx]] = 1'b1;
                end
            end
        end
    end

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] young_idx;
    assign young_idx = wr_ptr - PTR_W'(1);

    // Newest producer: the long unit first, then the youngest buffered entry.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_dest  = '0;
        fwd_data  = '0;
        if (reset) begin
            fwd_valid = 1'b0;
        end else if (lu_valid) begin
            fwd_valid = 1'b1;
            fwd_dest  = lu_dest;
            fwd_data  = lu_data;
        end else if (!fifo_empty && fifo_we[young_idx]) begin
            fwd_valid = 1'b1;
            fwd_dest  = fifo_dest[young_idx];
            fwd_data  = fifo_data[young_idx];
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_dest  = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Scoreboard bench for wb_retire_stage (default parameters).
// The driver runs a queue-based reference model and pushes the expected values into two queues.
// The first queue holds per-cycle records for allowin, mask and forwarding.
// The second queue holds the retire events. A negedge monitor pops both and compares them.
module tb_wb_retire_stage;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    typedef struct packed {
        logic        rst;
        logic        allow;
        logic [31:0] pend;
        logic        fv;
        logic [4:0]  fd;
        logic [31:0] fdat;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid, ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result, ms_pc;
    logic        ws_allowin;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data, lu_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    ent_t mq[$];   // reference FIFO contents
    ent_t rq[$];   // expected retire events
    cyc_t cq[$];   // expected per-cycle status

    always #5 clk = ~clk;

    wb_retire_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_result         (ms_result),
        .ms_pc             (ms_pc),
        .ws_allowin        (ws_allowin),
        .lu_valid          (lu_valid),
        .lu_dest           (lu_dest),
        .lu_data           (lu_data),
        .lu_pc             (lu_pc),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .pend_mask         (pend_mask),
        .fwd_valid         (fwd_valid),
        .fwd_dest          (fwd_dest),
        .fwd_data          (fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model by one clock.
    task automatic cycle(input logic v, input logic we, input logic [4:0] d,
                         input logic [31:0] r, input logic [31:0] p,
                         input logic lv, input logic [4:0] ld,
                         input logic [31:0] ldat, input logic [31:0] lp,
                         input logic rst);
        cyc_t c;
        ent_t e;
        logic pop;
        @(posedge clk);
        #1;
        reset = rst; ms_to_ws_valid = v; ms_gr_we = we; ms_dest = d; ms_result = r;
        ms_pc = p; lu_valid = lv; lu_dest = ld; lu_data = ldat; lu_pc = lp;
        c = '0;
        if (rst) begin
            c.rst = 1'b1;
            cq.push_back(c);
            mq.delete();
            return;
        end
        foreach (mq[i]) if (mq[i].we && mq[i].dest != 0) c.pend[mq[i].dest] = 1'b1;
`ifdef WB_FWD_EN
        if (lv) begin
            c.fv = 1'b1; c.fd = ld; c.fdat = ldat;
        end else if (mq.size() > 0 && mq[mq.size()-1].we) begin
            c.fv = 1'b1; c.fd = mq[mq.size()-1].dest; c.fdat = mq[mq.size()-1].data;
        end
`endif
        pop = 1'b0;
        if (lv) begin
            rq.push_back('{we: (ld != 0), dest: ld, data: ldat, pc: lp});
        end else if (mq.size() > 0) begin
            pop = 1'b1;
            e = mq[0];
            rq.push_back('{we: (e.we && e.dest != 0), dest: e.dest, data: e.data, pc: e.pc});
        end
        c.allow = (mq.size() < DEPTH) || pop;
        cq.push_back(c);
        if (pop) void'(mq.pop_front());
        if (v && c.allow) mq.push_back('{we: we, dest: d, data: r, pc: p});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT against the queued expectations away from the active edge.
    always @(negedge clk) begin
        cyc_t c;
        ent_t r;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            if (c.rst) begin
                chk("reset_rf_we", 64'(rf_we), 64'(0));
                chk("reset_pc", 64'(debug_wb_pc), 64'(0));
            end else begin
                chk("allowin", 64'(ws_allowin), 64'(c.allow));
                chk("pend_mask", 64'(pend_mask), 64'(c.pend));
                chk("fwd", {26'd0, fwd_valid, fwd_dest, fwd_data}, {26'd0, c.fv, c.fd, c.fdat});
                if (debug_wb_pc != 0 || rf_we) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_retire", 64'(debug_wb_pc), 64'(0));
                    end else begin
                        r = rq.pop_front();
                        chk("retire_pc", 64'(debug_wb_pc), 64'(r.pc));
                        chk("retire_we", 64'(rf_we), 64'(r.we));
                        chk("retire_addr", 64'(rf_waddr), 64'(r.dest));
                        chk("retire_data", 64'(rf_wdata), 64'(r.data));
                        chk("trace", {debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
                            {{4{r.we}}, r.dest, r.data});
                    end
                end else begin
                    chk("idle_rf_we", 64'(rf_we), 64'(0));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; ms_to_ws_valid = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0;
        ms_pc = 0; lu_valid = 0; lu_dest = 0; lu_data = 0; lu_pc = 0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Single push, which retires on the following cycle.
        cycle(1, 1, 5, 32'h1234, 32'hbfc00000, 0, 0, 0, 0, 0);
        idle(2);

        // Six pushes while lu holds the port for five cycles.
        for (int i = 0; i < 6; i++)
            cycle(1, 1, 5'(10 + i), 32'h100 + i, 32'h8000_0000 + 4 * i,
                  (i < 5), 5'(20 + i), 32'h2000 + i, 32'h9000_0000 + 4 * i, 0);
        // Fill again under lu, then push into the full FIFO while the head retires.
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 5'(1 + i), 32'h300 + i, 32'h8100_0000 + 4 * i,
                  1, 5'(30), 32'h4000 + i, 32'h9100_0000 + 4 * i, 0);
        cycle(1, 1, 5'd17, 32'h555, 32'h8200_0000, 0, 0, 0, 0, 0);
        idle(8);

        // Mask filtering: we=0 and dest=0 entries never appear.
        cycle(1, 1, 3, 32'h33, 32'h8300_0000, 1, 4, 32'h44, 32'h9300_0000, 0);
        cycle(1, 0, 7, 32'h77, 32'h8300_0004, 1, 4, 32'h45, 32'h9300_0004, 0);
        cycle(1, 1, 0, 32'h99, 32'h8300_0008, 1, 0, 32'h46, 32'h9300_0008, 0);
        idle(5);

        // Reset with three buffered entries.
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 5'(11 + i), 32'h600 + i, 32'h8400_0000 + 4 * i,
                  1, 2, 32'h700 + i, 32'h9400_0000 + 4 * i, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Two producers of r9 while the head is held off, then the port is released.
        cycle(1, 1, 9, 32'hA, 32'h8500_0000, 1, 6, 32'h66, 32'h9500_0000, 0);
        cycle(1, 1, 9, 32'hB, 32'h8500_0004, 1, 6, 32'h67, 32'h9500_0004, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] d;
            logic [4:0] ld;
            d  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ld = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), d, $urandom,
                  $urandom | 32'h1, ($urandom_range(0, 4) == 0), ld, $urandom,
                  $urandom | 32'h1, ($urandom_range(0, 199) == 0));
        end

        // Drain with a bounded number of cycles.
        for (int i = 0; i < 16 && mq.size() > 0; i++) idle(1);
        idle(1);
        @(negedge clk);
        #1;
        chk("retire_queue_drained", 64'(rq.size()), 64'(0));
        chk("model_fifo_drained", 64'(mq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
